// File: rtl/gato_pkg.sv
// gato_pkg: state type and encodings shared by the gato turn controller
package gato_pkg;
    typedef logic [2:0] state_t;
    localparam state_t S_P1_TURN  = 3'd0;
    localparam state_t S_P1_CHECK = 3'd1;
    localparam state_t S_P2_TURN  = 3'd2;
    localparam state_t S_P2_CHECK = 3'd3;
    localparam state_t S_P1_WINS  = 3'd4;
    localparam state_t S_P2_WINS  = 3'd5;
    localparam state_t S_TIE      = 3'd6;
endpackage

// File: rtl/gato_fsm.sv
// gato_fsm: alternates player turns, requests a one-cycle board check after
// every move and latches the game result until reset
module gato_fsm
    import gato_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] state,
    input  logic       p1_mm,
    input  logic       p2_mm,
    input  logic       p1_tie,
    input  logic       p1_loss,
    input  logic       p1_win,
    input  logic       p2_tie,
    input  logic       p2_loss,
    input  logic       p2_win,
    output logic       verifica_status,
    output logic       turno_p1,
    output logic       turno_p2
);
    state_t next_state;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_P1_TURN;
        else       state <= next_state;

    // a loss for one player is a win for the other; win > loss > tie
    always_comb begin
        next_state = state;
        case (state)
            S_P1_TURN:  next_state = p1_mm ? S_P1_CHECK : S_P1_TURN;
            S_P1_CHECK: next_state = p1_win ? S_P1_WINS : p1_loss ? S_P2_WINS : p1_tie ? S_TIE : S_P2_TURN;
            S_P2_TURN:  next_state = p2_mm ? S_P2_CHECK : S_P2_TURN;
            S_P2_CHECK: next_state = p2_win ? S_P2_WINS : p2_loss ? S_P1_WINS : p2_tie ? S_TIE : S_P1_TURN;
            S_P1_WINS, S_P2_WINS, S_TIE: next_state = state;
            default:    next_state = S_P1_TURN;
        endcase
    end

    always_comb begin
        turno_p1        = state == S_P1_TURN;
        turno_p2        = state == S_P2_TURN;
        verifica_status = state == S_P1_CHECK || state == S_P2_CHECK;
    end
endmodule

// File: tb/tb_gato_fsm.sv
// tb_gato_fsm: directed checks of turn alternation, results, priority and reset
module tb_gato_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] state;
    logic p1_mm = 0, p2_mm = 0;
    logic p1_tie = 0, p1_loss = 0, p1_win = 0;
    logic p2_tie = 0, p2_loss = 0, p2_win = 0;
    logic verifica_status, turno_p1, turno_p2;
    int checks = 0;
    int errors = 0;

    localparam logic [2:0] O_P1 = 3'b100, O_P2 = 3'b010, O_CK = 3'b001, O_NO = 3'b000;

    gato_fsm dut (
        .clk(clk), .reset(reset), .state(state),
        .p1_mm(p1_mm), .p2_mm(p2_mm),
        .p1_tie(p1_tie), .p1_loss(p1_loss), .p1_win(p1_win),
        .p2_tie(p2_tie), .p2_loss(p2_loss), .p2_win(p2_win),
        .verifica_status(verifica_status), .turno_p1(turno_p1), .turno_p2(turno_p2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] es, input logic [2:0] eo);
        checks++;
        assert (state === es) else begin
            errors++;
            $error("FAIL %s state=%0d expected=%0d", tag, state, es);
        end
        checks++;
        assert ({turno_p1, turno_p2, verifica_status} === eo) else begin
            errors++;
            $error("FAIL %s outputs{p1,p2,chk}=%b expected=%b", tag, {turno_p1, turno_p2, verifica_status}, eo);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] es, input logic [2:0] eo);
        @(posedge clk);
        #1;
        chk(tag, es, eo);
    endtask

    // reset raised between edges must take effect before the next edge
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1 chk(tag, 3'd0, O_P1);
        @(posedge clk);
        #1 chk({tag, "_held"}, 3'd0, O_P1);
        reset = 1'b0;
        {p1_mm, p2_mm, p1_tie, p1_loss, p1_win, p2_tie, p2_loss, p2_win} = '0;
    endtask

    initial begin
        #2 chk("reset_init", 3'd0, O_P1);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("after_release", 3'd0, O_P1);

        p2_mm = 1;
        step("p2mm_in_p1turn", 3'd0, O_P1);
        p2_mm = 0; p1_mm = 1;
        step("p1_move", 3'd1, O_CK);
        step("to_p2", 3'd2, O_P2);
        step("p1mm_in_p2turn", 3'd2, O_P2);
        p1_mm = 0; p2_mm = 1;
        step("p2_move", 3'd3, O_CK);
        step("to_p1", 3'd0, O_P1);
        p2_mm = 0;
        step("hold_p1", 3'd0, O_P1);
        p1_mm = 1; p2_mm = 1;
        step("lvl_1", 3'd1, O_CK);
        step("lvl_2", 3'd2, O_P2);
        step("lvl_3", 3'd3, O_CK);
        step("lvl_0", 3'd0, O_P1);
        step("lvl_1b", 3'd1, O_CK);
        p1_mm = 0;
        step("lvl_2b", 3'd2, O_P2);
        step("lvl_3b", 3'd3, O_CK);
        p2_mm = 0;
        do_reset("reset_in_s3");

        p1_mm = 1;
        step("restart_1", 3'd1, O_CK);
        p1_mm = 0; p2_win = 1;
        step("p2win_in_p1check", 3'd2, O_P2);
        p2_win = 0; p2_mm = 1;
        step("p2_move_w", 3'd3, O_CK);
        p2_mm = 0; p2_win = 1;
        step("p2_wins", 3'd5, O_NO);
        p2_win = 0; p1_mm = 1; p2_mm = 1;
        step("p2_wins_hold1", 3'd5, O_NO);
        step("p2_wins_hold2", 3'd5, O_NO);
        do_reset("reset_in_s5");

        p1_mm = 1;
        step("p1_move_w", 3'd1, O_CK);
        p1_mm = 0; p1_win = 1;
        step("p1_wins", 3'd4, O_NO);
        p1_win = 0; p1_mm = 1; p2_mm = 1;
        for (int i = 0; i < 5; i++) step("p1_wins_hold", 3'd4, O_NO);
        do_reset("reset_in_s4");

        p1_mm = 1;
        step("p1_move_l", 3'd1, O_CK);
        p1_mm = 0; p1_loss = 1;
        step("p1_loss", 3'd5, O_NO);
        do_reset("reset_after_p1loss");

        p1_mm = 1;
        step("p1_move_t", 3'd1, O_CK);
        p1_mm = 0; p1_tie = 1;
        step("p1_tie", 3'd6, O_NO);
        do_reset("reset_after_p1tie");

        p1_mm = 1;
        step("p1_move_pl", 3'd1, O_CK);
        p1_mm = 0; p1_loss = 1; p1_tie = 1;
        step("prio_loss_tie", 3'd5, O_NO);
        do_reset("reset_after_prio1");

        p1_mm = 1;
        step("p1_move_pa", 3'd1, O_CK);
        p1_mm = 0; p1_win = 1; p1_loss = 1; p1_tie = 1;
        step("prio_all", 3'd4, O_NO);
        do_reset("reset_after_prio2");

        p1_mm = 1;
        step("l2_1", 3'd1, O_CK);
        p1_mm = 0;
        step("l2_2", 3'd2, O_P2);
        p2_mm = 1; p1_win = 1;
        step("l2_3", 3'd3, O_CK);
        p2_mm = 0; p1_win = 0; p2_loss = 1;
        step("p2_loss", 3'd4, O_NO);
        do_reset("reset_after_p2loss");

        p1_mm = 1;
        step("t2_1", 3'd1, O_CK);
        p1_mm = 0;
        step("t2_2", 3'd2, O_P2);
        p2_mm = 1;
        step("t2_3", 3'd3, O_CK);
        p2_mm = 0; p2_tie = 1;
        step("p2_tie", 3'd6, O_NO);
        p2_tie = 0;
        step("tie_hold", 3'd6, O_NO);
        do_reset("reset_in_s6");

        p1_mm = 1;
        step("restart_after_tie", 3'd1, O_CK);
        p1_mm = 0;
        step("restart_p2", 3'd2, O_P2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
